t03_vga_timing: RTL and testbench

- Raster timing generator that drives the Hcnt/Vcnt pixel coordinates consumed by every sprite and text display stage (player displays, board, score), plus hsync/vsync/active for the VGA pins.
- Display stages register their colour, so each pixel arrives one cycle late. This block also emits copies of sync/active delayed by PIPE_DLY pixel ticks, so the final colour mux lines up with the pins.
- Provides frame_start/line_start pulses and a frame counter for game-tick and animation logic.

---
 rtl/t03_vga_pkg.sv | 38 +++
 rtl/t03_sync_delay.sv | 39 +++
 rtl/t03_vga_timing.sv | 128 ++++++++++++
 tb/tb_t03_vga_timing.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/t03_vga_pkg.sv
// Shared raster constants and types for the VGA timing block and the display
// stages that consume its pixel coordinates.
package t03_vga_pkg;

    // Width of the Hcnt/Vcnt coordinate buses seen by every display stage.
    localparam int COORD_W     = 11;
    localparam int COLOR_W     = 8;
    localparam int FRAME_CNT_W = 8;

    // Largest total that still fits in a COORD_W-bit counter.
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    // Standard 640x480 @ 60 Hz timing.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Bundle of raster qualifiers that travels through the pipeline delay.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_bundle_t;

    // Pin level for a sync signal given whether the count sits in its window.
    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/t03_sync_delay.sv
// En-gated shift register used to align sync/active with registered colour
// stages. DEPTH=0 degenerates to a plain wire.
module t03_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        // Shift one stage per pixel tick; reset loads the inactive pattern.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= RST_VAL;
                end
            end else if (en) begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/t03_vga_timing.sv
// Raster timing generator: pixel coordinates, sync/active qualifiers with a
// pipeline-aligned delayed copy, line/frame pulses and a frame counter.
module t03_vga_timing
    import t03_vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE_DLY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [COORD_W-1:0]     Hcnt,
    output logic [COORD_W-1:0]     Vcnt,
    output logic                   active,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hsync_d,
    output logic                   vsync_d,
    output logic                   active_d,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Refuse to build a raster the 11-bit counters cannot represent.
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("t03_vga_timing: H_TOTAL/V_TOTAL must be below 2048");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("t03_vga_timing: PIPE_DLY must be in 0..7");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bundle_t IDLE_BUNDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};

    logic               h_wrap;
    logic               v_wrap;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               active_next;
    logic               hsync_next;
    logic               vsync_next;

    // Next raster position and the qualifiers that describe it, so the
    // registered qualifiers carry zero skew relative to the counts.
    always_comb begin
        h_wrap      = (Hcnt == H_LAST);
        v_wrap      = (Vcnt == V_LAST);
        h_next      = h_wrap ? '0 : Hcnt + COORD_W'(1);
        v_next      = Vcnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : Vcnt + COORD_W'(1);
        end
        active_next = (h_next < H_VIS) && (v_next < V_VIS);
        hsync_next  = sync_level((h_next >= HS_START) && (h_next < HS_END), SYNC_POL);
        vsync_next  = sync_level((v_next >= VS_START) && (v_next < VS_END), SYNC_POL);
    end

    // Raster counters, qualifiers, one-clock pulses and the frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            Hcnt        <= '0;
            Vcnt        <= '0;
            active      <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                Hcnt        <= h_next;
                Vcnt        <= v_next;
                active      <= active_next;
                hsync       <= hsync_next;
                vsync       <= vsync_next;
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                end
            end
        end
    end

    sync_bundle_t bundle_now;
    sync_bundle_t bundle_dly;

    assign bundle_now = '{hsync: hsync, vsync: vsync, active: active};

    t03_sync_delay #(
        .WIDTH   ($bits(sync_bundle_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (IDLE_BUNDLE)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (bundle_now),
        .dout (bundle_dly)
    );

    assign hsync_d  = bundle_dly.hsync;
    assign vsync_d  = bundle_dly.vsync;
    assign active_d = bundle_dly.active;

endmodule

// File: tb/tb_t03_vga_timing.sv
// Scoreboard bench for t03_vga_timing on a shrunken raster so that more than
// 256 whole frames fit in a short run. Expected outputs are derived from the
// number of pixel ticks since reset.
module tb_t03_vga_timing;
    import t03_vga_pkg::*;

    localparam int   HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int   VA = 4, VF = 1, VS = 1, VB = 2;
    localparam int   D  = 2;
    localparam logic POL = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FT = HT * VT;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en  = 1'b0;
    logic [COORD_W-1:0]     Hcnt, Vcnt;
    logic                   active, hsync, vsync, hsync_d, vsync_d, active_d;
    logic                   line_start, frame_start;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    typedef struct packed {
        logic [COORD_W-1:0]     h;
        logic [COORD_W-1:0]     v;
        logic                   act;
        logic                   hs;
        logic                   vs;
        logic                   hs_d;
        logic                   vs_d;
        logic                   act_d;
        logic                   ls;
        logic                   fs;
        logic [FRAME_CNT_W-1:0] fc;
    } obs_t;

    obs_t        sb_q[$];
    obs_t        mon_exp;
    int unsigned tick_idx = 0;
    logic        exp_ls   = 1'b0;
    logic        exp_fs   = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    t03_vga_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .PIPE_DLY (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .hsync_d     (hsync_d),
        .vsync_d     (vsync_d),
        .active_d    (active_d),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    function automatic logic in_win(int unsigned x, int lo, int width);
        return (x >= lo) && (x < lo + width);
    endfunction

    // Expected outputs after t pixel ticks since the last reset.
    function automatic obs_t expected_at(int unsigned t, logic ls, logic fs);
        obs_t        o;
        int unsigned h = t % HT;
        int unsigned v = (t / HT) % VT;
        o.h   = COORD_W'(h);
        o.v   = COORD_W'(v);
        o.act = (h < HA) && (v < VA);
        o.hs  = in_win(h, HA + HF, HS) ? POL : ~POL;
        o.vs  = in_win(v, VA + VF, VS) ? POL : ~POL;
        if (t >= D) begin
            int unsigned hd = (t - D) % HT;
            int unsigned vd = ((t - D) / HT) % VT;
            o.hs_d  = in_win(hd, HA + HF, HS) ? POL : ~POL;
            o.vs_d  = in_win(vd, VA + VF, VS) ? POL : ~POL;
            o.act_d = (hd < HA) && (vd < VA);
        end else begin
            o.hs_d  = ~POL;
            o.vs_d  = ~POL;
            o.act_d = 1'b0;
        end
        o.ls = ls;
        o.fs = fs;
        o.fc = FRAME_CNT_W'((t / FT) % 256);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("H=%0d V=%0d act=%b hs=%b vs=%b hs_d=%b vs_d=%b act_d=%b ls=%b fs=%b fc=%0d",
                         o.h, o.v, o.act, o.hs, o.vs, o.hs_d, o.vs_d, o.act_d, o.ls, o.fs, o.fc);
    endfunction

    task automatic applyStimulus(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            tick_idx = 0;
            exp_ls   = 1'b0;
            exp_fs   = 1'b0;
        end else if (e) begin
            tick_idx = tick_idx + 1;
            exp_ls   = (tick_idx % HT) == 0;
            exp_fs   = (tick_idx % FT) == 0;
        end else begin
            exp_ls = 1'b0;
            exp_fs = 1'b0;
        end
        sb_q.push_back(expected_at(tick_idx, exp_ls, exp_fs));
    endtask

    task automatic checkOutput(input obs_t exp_o);
        obs_t got;
        got = '{h: Hcnt, v: Vcnt, act: active, hs: hsync, vs: vsync,
                hs_d: hsync_d, vs_d: vsync_d, act_d: active_d,
                ls: line_start, fs: frame_start, fc: frame_cnt};
        n_checks++;
        if (got !== exp_o) begin
            n_fail++;
            $display("[TB] FAIL raster @%0t: got %s | expected %s", $time, fmt(got), fmt(exp_o));
        end
    endtask

    // Monitor: one expected entry per clock edge issued by the stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                checkOutput(mon_exp);
            end
        end
    end

    // Stimulus: reset, mid-raster reset inside both sync windows, alternating
    // en, then a long random-en run past the 256-frame wrap.
    initial begin
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);

        for (int i = 0; i < 200 && tick_idx != (VA + VF) * HT + HA + HF + 1; i++) begin
            applyStimulus(1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 2 * FT + 20; i++) begin
            applyStimulus(1'b0, (i % 2) == 0);
        end

        for (int i = 0; i < 60000 && tick_idx < 256 * FT + 3 * HT; i++) begin
            applyStimulus(1'b0, $urandom_range(3, 0) != 0);
        end

        applyStimulus(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        n_checks++;
        if (tick_idx < 256 * FT) begin
            n_fail++;
            $display("[TB] FAIL coverage: %0d ticks run, expected at least %0d", tick_idx, 256 * FT);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
